// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the round-robin encoder arbiter.
// Holds the FSM state encodings and the default sizing parameters.
package arb_pkg;

    localparam int ARB_N        = 8;
    localparam int ARB_IDX_W    = 3;
    localparam int ARB_MAX_HOLD = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: combinational round-robin search.
// The request vector is rotated so that bit ptr becomes bit 0. The lowest set
// bit is then picked, and its position is rotated back into requester numbering.
module rr_priority_encoder
    import arb_pkg::*;
#(
    parameter int N     = ARB_N,
    parameter int IDX_W = ARB_IDX_W
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [N-1:0]     winner_oh,
    output logic [IDX_W-1:0] winner_idx
);

    logic [2*N-1:0]   doubled;
    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] rot_idx;

    // Rotate, priority-encode the lowest set bit, then un-rotate the index
    always_comb begin
        doubled = {req, req};
        rotated = doubled[ptr +: N];
        found   = 1'b0;
        rot_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found   = 1'b1;
                rot_idx = IDX_W'(i);
            end
        end
        winner_idx            = IDX_W'((int'(rot_idx) + int'(ptr)) % N);
        winner_oh             = '0;
        winner_oh[winner_idx] = found;
    end

endmodule : rr_priority_encoder

// File: rtl/rr_encoder_arbiter.sv
// rr_encoder_arbiter: round-robin owner selection for a shared encoder.
// A grant is held until the owner pulses done or drops its request; on release
// the next owner is chosen in the same cycle so the encoder enable never dips.
// Define ARB_TIMEOUT_EN to add a hold counter that forcibly revokes a grant
// after MAX_HOLD cycles and pulses timeout; otherwise timeout is tied low.
module rr_encoder_arbiter
    import arb_pkg::*;
#(
    parameter int N     = ARB_N,
    parameter int IDX_W = ARB_IDX_W
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = ARB_MAX_HOLD
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;

    logic             found;
    logic [N-1:0]     win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             rel_evt;
    logic             forced_evt;
    logic             new_grant;

    rr_priority_encoder #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_search (
        .req        (req),
        .ptr        (ptr_q),
        .found      (found),
        .winner_oh  (win_oh),
        .winner_idx (win_idx)
    );

    assign rel_evt = (state_q == ST_GRANT) && (done || !req[gnt_idx_q]);

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              timeout_q, timeout_d;

    assign forced_evt = (state_q == ST_GRANT) && !rel_evt &&
                        (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    assign timeout    = timeout_q;
`else
    assign forced_evt = 1'b0;
    assign timeout    = 1'b0;
`endif

    // Next-state logic: grant from idle, hold, or re-arbitrate on release
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        new_grant   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    new_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                if (rel_evt || forced_evt) begin
`ifdef ARB_TIMEOUT_EN
                    timeout_d = forced_evt;
`endif
                    if (found) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        gnt_d       = '0;
                        gnt_idx_d   = '0;
                        gnt_valid_d = 1'b0;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = hold_cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (new_grant) begin
            state_d     = ST_GRANT;
            gnt_d       = win_oh;
            gnt_idx_d   = win_idx;
            gnt_valid_d = 1'b1;
            ptr_d       = IDX_W'((int'(win_idx) + 1) % N);
`ifdef ARB_TIMEOUT_EN
            hold_cnt_d  = '0;
`endif
        end
    end

    // State and output registers; reset wins over any release or timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule : rr_encoder_arbiter

// File: tb/tb_rr_encoder_arbiter.sv
// tb_rr_encoder_arbiter: directed scenarios followed by random traffic, all
// checked against a behavioural owner/pointer model of the arbiter.
// Timeout expectations follow ARB_TIMEOUT_EN when it is defined.
module tb_rr_encoder_arbiter;

    localparam int N        = 8;
    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model: who owns the encoder, where the next search starts,
    // how long the current owner has held it and whether it was just revoked
    int m_owner   = -1;
    int m_next    = 0;
    int m_hold    = 0;
    bit m_timeout = 1'b0;

    rr_encoder_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // First requester at or after 'start' in circular order, or -1
    function automatic int pickWinner(logic [7:0] r, int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic void takeOwner(int w);
        m_owner = w;
        m_next  = (w + 1) % N;
        m_hold  = 0;
    endfunction

    // Advance the model by one clock edge with the given inputs
    function automatic void modelStep(logic [7:0] r, logic d, logic rst);
        bit rel;
        bit frc;
        int w;
        m_timeout = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_next  = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            w = pickWinner(r, m_next);
            if (w >= 0) takeOwner(w);
        end else begin
            rel = d || !r[m_owner];
            frc = 1'b0;
`ifdef ARB_TIMEOUT_EN
            frc = !rel && (m_hold == MAX_HOLD - 1);
`endif
            if (rel || frc) begin
                m_timeout = frc;
                w = pickWinner(r, (m_owner + 1) % N);
                if (w >= 0) takeOwner(w);
                else begin
                    m_next  = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end else begin
                m_hold++;
            end
        end
    endfunction

    task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_vectors++;
        assert (observed === expected) else begin
            n_miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compare all outputs with the model's view of the current owner
    task automatic checkOutput(input string tag);
        logic [7:0] exp_gnt;
        logic [7:0] exp_idx;
        exp_gnt = 8'h00;
        exp_idx = 8'h00;
        if (m_owner >= 0) begin
            exp_gnt[m_owner] = 1'b1;
            exp_idx = 8'(m_owner);
        end
        n_vectors++;
        assert ((gnt === exp_gnt) && (gnt_idx === exp_idx[2:0]) &&
                (gnt_valid === (m_owner >= 0)) && (timeout === m_timeout)) else begin
            n_miscompares++;
            $error("[TB] FAIL %s: observed gnt=%0h idx=%0d valid=%0b to=%0b expected gnt=%0h idx=%0d valid=%0b to=%0b",
                   tag, gnt, gnt_idx, gnt_valid, timeout, exp_gnt, exp_idx, m_owner >= 0, m_timeout);
        end
    endtask

    // Drive one cycle of inputs away from the active edge, then check
    task automatic applyStimulus(input logic [7:0] r, input logic d, input logic rst, input string tag);
        @(negedge clk);
        req   = r;
        done  = d;
        reset = rst;
        modelStep(r, d, rst);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [7:0] rnd_req;
        logic       rnd_done;
        logic       rnd_rst;

        req   = 8'h00;
        done  = 1'b0;
        reset = 1'b1;

        // Idle after reset
        applyStimulus(8'h00, 1'b0, 1'b1, "reset0");
        applyStimulus(8'h00, 1'b0, 1'b1, "reset1");
        for (int i = 0; i < 5; i++) applyStimulus(8'h00, 1'b0, 1'b0, "idle");
        checkValue("idle_gnt", gnt, 8'h00);

        // Priority from ptr=0 and back-to-back handover
        applyStimulus(8'h28, 1'b0, 1'b0, "grant3");
        checkValue("grant3_gnt", gnt, 8'h08);
        checkValue("grant3_idx", {5'd0, gnt_idx}, 8'd3);
        applyStimulus(8'h28, 1'b0, 1'b0, "hold3");
        applyStimulus(8'h28, 1'b1, 1'b0, "handover5");
        checkValue("handover5_gnt", gnt, 8'h20);
        checkValue("handover5_valid", {7'd0, gnt_valid}, 8'd1);
        applyStimulus(8'h2c, 1'b0, 1'b0, "ignore_nonowner");

        // Wrap-around through owner 7
        applyStimulus(8'h80, 1'b0, 1'b0, "to7");
        applyStimulus(8'h81, 1'b1, 1'b0, "wrap0");
        checkValue("wrap0_idx", {5'd0, gnt_idx}, 8'd0);
        applyStimulus(8'h81, 1'b1, 1'b0, "wrap7");
        checkValue("wrap7_idx", {5'd0, gnt_idx}, 8'd7);

        // Release by dropping req, then resume from the rotated pointer
        applyStimulus(8'h00, 1'b0, 1'b0, "drop7");
        applyStimulus(8'h04, 1'b0, 1'b0, "grant2");
        applyStimulus(8'h00, 1'b0, 1'b0, "drop2");
        checkValue("drop2_valid", {7'd0, gnt_valid}, 8'd0);
        applyStimulus(8'h02, 1'b0, 1'b0, "grant1");
        checkValue("grant1_idx", {5'd0, gnt_idx}, 8'd1);
        applyStimulus(8'h02, 1'b0, 1'b0, "done_in_grant1");
        applyStimulus(8'h00, 1'b1, 1'b0, "done_in_idle");

        // Reset mid-grant clears the pointer as well
        applyStimulus(8'h10, 1'b0, 1'b0, "grant4");
        checkValue("grant4_idx", {5'd0, gnt_idx}, 8'd4);
        applyStimulus(8'h10, 1'b1, 1'b1, "reset_mid");
        checkValue("reset_mid_gnt", gnt, 8'h00);
        applyStimulus(8'h30, 1'b0, 1'b0, "after_reset4");
        checkValue("after_reset4_idx", {5'd0, gnt_idx}, 8'd4);

        // Long hold: revoked after MAX_HOLD cycles only when timeout is built in
        applyStimulus(8'h00, 1'b0, 1'b1, "reset_long");
        applyStimulus(8'h06, 1'b0, 1'b0, "long_grant1");
        for (int i = 0; i < 40; i++) applyStimulus(8'h06, 1'b0, 1'b0, "long_hold");

        // Random traffic: sticky requests, occasional done and reset
        rnd_req = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rnd_req = 8'($urandom);
            rnd_done = ($urandom_range(0, 5) == 0);
            rnd_rst  = ($urandom_range(0, 59) == 0);
            applyStimulus(rnd_req, rnd_done, rnd_rst, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_rr_encoder_arbiter
